// File: rtl/bit_to_array_packer_if.sv
// -----------------------------------------------------------------------------
// bit_to_array_packer_if
//
// Purpose : holds the packer's accumulating word as a packed-array member so
//           the accumulator lives in one named container inside the packer.
//
// Parameters:
//   WIDTH - word width in bits (>= 2)
//
// Members:
//   acc_r [WIDTH-1:0] - accumulating word; positions not yet written are zero
// -----------------------------------------------------------------------------
interface bit_to_array_packer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] acc_r;
endinterface

// File: rtl/bit_to_array_packer.sv
// -----------------------------------------------------------------------------
// bit_to_array_packer
//
// Purpose : serial-to-parallel packer. Scalar bits, one per accepted beat, are
//           gathered into a WIDTH-bit word. Complete words are presented on a
//           valid/ready output. The block is double-buffered: accumulation
//           continues while the previous word waits at the output.
//
// Parameters:
//   WIDTH     - word width in bits (>= 2)
//   MSB_FIRST - 0: first accepted bit lands in bit 0
//               1: first accepted bit lands in bit WIDTH-1
//
// Optional feature (macro BIT_TO_ARRAY_PACKER_FLUSH_EN):
//   defined   - i_flush closes a partial word. Missing positions are zero and
//               o_bits reports how many bits are valid.
//   undefined - i_flush is ignored. o_bits is WIDTH whenever o_valid is high.
//
// Ports:
//   i_clk   in  1                   clock, rising edge
//   i_rst_n in  1                   synchronous active-low reset
//   i_valid in  1                   input bit valid
//   i_bit   in  1                   scalar data bit
//   o_ready out 1                   packer can accept a bit this cycle
//   i_flush in  1                   close a partial word (flush build only)
//   o_valid out 1                   o_data holds a word
//   i_ready in  1                   consumer accepts the word
//   o_data  out WIDTH               packed word
//   o_bits  out $clog2(WIDTH+1)     number of valid bits in o_data
// -----------------------------------------------------------------------------
module bit_to_array_packer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic                       i_bit,
  output logic                       o_ready,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(WIDTH+1)-1:0] o_bits
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    WIDTH_C    = CW'(WIDTH);
  localparam logic [CW-1:0]    WIDTH_M1_C = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ACC_ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ACC_ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Accumulator container
  bit_to_array_packer_if #(.WIDTH(WIDTH)) acc_if ();

  // Registered state
  logic [CW-1:0]    cnt_r;
  logic             o_valid_r;
  logic [WIDTH-1:0] o_data_r;
  logic [CW-1:0]    o_bits_r;

  // Derived per-cycle signals
  logic             ready_s;
  logic             accept_s;
  logic             out_free_s;
  logic             pending_s;
  logic             done_s;
  logic [CW-1:0]    pos_s;
  logic [WIDTH-1:0] bit_mask_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             flush_take_s;
  logic             load_s;
  logic [CW-1:0]    load_bits_s;

`ifdef BIT_TO_ARRAY_PACKER_FLUSH_EN
  logic [CW-1:0]    n_bits_s;
`else
  logic             unused_flush_s;
  assign unused_flush_s = i_flush;
`endif

  // Handshake, bit placement and word-completion decode
  always_comb begin
    pending_s  = (cnt_r == WIDTH_C);
    // o_ready is forced low while reset is asserted, even combinationally
    ready_s    = i_rst_n && !pending_s;
    accept_s   = i_valid && ready_s;
    out_free_s = !o_valid_r || i_ready;
    done_s     = accept_s && (cnt_r == WIDTH_M1_C);

    if (MSB_FIRST) begin
      pos_s = WIDTH_M1_C - cnt_r;
    end else begin
      pos_s = cnt_r;
    end

    // pos_s is only meaningful when accept_s is set, which implies cnt_r < WIDTH
    bit_mask_s = ACC_ONE_C << pos_s;

    if (accept_s && i_bit) begin
      acc_next_s = acc_if.acc_r | bit_mask_s;
    end else begin
      acc_next_s = acc_if.acc_r;
    end

`ifdef BIT_TO_ARRAY_PACKER_FLUSH_EN
    if (accept_s) begin
      n_bits_s = cnt_r + CNT_ONE_C;
    end else begin
      n_bits_s = cnt_r;
    end
    // A pending full word is never flushed; it drains as a normal completion
    flush_take_s = i_flush && !pending_s && (n_bits_s != CNT_ZERO_C) && out_free_s;
`else
    flush_take_s = 1'b0;
`endif

    load_s = ((done_s || pending_s) && out_free_s) || flush_take_s;

`ifdef BIT_TO_ARRAY_PACKER_FLUSH_EN
    if (done_s || pending_s) begin
      load_bits_s = WIDTH_C;
    end else begin
      load_bits_s = n_bits_s;
    end
`else
    load_bits_s = WIDTH_C;
`endif
  end

  // Accumulator, bit counter and output register update
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_r        <= CNT_ZERO_C;
      acc_if.acc_r <= ACC_ZERO_C;
      o_valid_r    <= 1'b0;
      o_data_r     <= ACC_ZERO_C;
      o_bits_r     <= CNT_ZERO_C;
    end else if (load_s) begin
      // Output slot is free: move the finished (or flushed) word across and
      // restart the accumulator, so a new word can start on the next beat
      o_data_r     <= acc_next_s;
      o_bits_r     <= load_bits_s;
      o_valid_r    <= 1'b1;
      cnt_r        <= CNT_ZERO_C;
      acc_if.acc_r <= ACC_ZERO_C;
    end else begin
      // A completion with the output still held lands here: cnt_r reaches
      // WIDTH, which drops o_ready until the held word is consumed
      if (accept_s) begin
        acc_if.acc_r <= acc_next_s;
        cnt_r        <= cnt_r + CNT_ONE_C;
      end else begin
        acc_if.acc_r <= acc_if.acc_r;
        cnt_r        <= cnt_r;
      end

      if (o_valid_r && i_ready) begin
        o_valid_r <= 1'b0;
      end else begin
        o_valid_r <= o_valid_r;
      end

      o_data_r <= o_data_r;
      o_bits_r <= o_bits_r;
    end
  end

  assign o_ready = ready_s;
  assign o_valid = o_valid_r;
  assign o_data  = o_data_r;
  assign o_bits  = o_bits_r;

endmodule

// File: tb/tb_bit_to_array_packer.sv
// -----------------------------------------------------------------------------
// tb_bit_to_array_packer
//
// Two packers (LSB-first and MSB-first) share all inputs. A bit-level
// scoreboard builds the expected word for each ordering as bits are accepted
// and compares it when the output handshake fires. Directed checks cover
// reset values, pulse width, backpressure, throughput and reset discard.
// -----------------------------------------------------------------------------
module tb_bit_to_array_packer;

  localparam int W  = 8;
  localparam int BW = $clog2(W + 1);

`ifdef BIT_TO_ARRAY_PACKER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic          clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          i_bit;
  logic          i_flush;
  logic          i_ready;
  logic          o_ready0, o_ready1;
  logic          o_valid0, o_valid1;
  logic [W-1:0]  o_data0, o_data1;
  logic [BW-1:0] o_bits0, o_bits1;

  bit_to_array_packer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_bit   (i_bit),
    .o_ready (o_ready0),
    .i_flush (i_flush),
    .o_valid (o_valid0),
    .i_ready (i_ready),
    .o_data  (o_data0),
    .o_bits  (o_bits0)
  );

  bit_to_array_packer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_bit   (i_bit),
    .o_ready (o_ready1),
    .i_flush (i_flush),
    .o_valid (o_valid1),
    .i_ready (i_ready),
    .o_data  (o_data1),
    .o_bits  (o_bits1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d0;
    logic [W-1:0]  d1;
    logic [BW-1:0] nb;
  } exp_t;

  exp_t         exp_q[$];
  int           vectors    = 0;
  int           miscompares = 0;
  int           nbits      = 0;
  logic [W-1:0] w0         = '0;
  logic [W-1:0] w1         = '0;
  int           cyc        = 0;
  int           valid_cycles = 0;
  logic         smp_ready, smp_valid, smp_ready1;
  logic [W-1:0] smp_data0, smp_data1;
  logic [BW-1:0] smp_bits0;
  logic         last_accept;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample at negedge, update scoreboard, advance
  task automatic step(input logic v, input logic b, input logic r,
                      input logic f, input logic rs);
    exp_t e;
    i_valid = v; i_bit = b; i_ready = r; i_flush = f; i_rst_n = rs;
    @(negedge clk);
    smp_ready  = o_ready0;
    smp_ready1 = o_ready1;
    smp_valid  = o_valid0;
    smp_data0  = o_data0;
    smp_data1  = o_data1;
    smp_bits0  = o_bits0;
    last_accept = v && o_ready0;
    if (o_valid0) valid_cycles++;
    if (!rs) begin
      exp_q.delete();
      nbits = 0; w0 = '0; w1 = '0;
    end else begin
      if (o_valid0 && r) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(o_data0), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("data_lsb", 32'(o_data0), 32'(e.d0));
          check("data_msb", 32'(o_data1), 32'(e.d1));
          check("bits_lsb", 32'(o_bits0), 32'(e.nb));
          check("bits_msb", 32'(o_bits1), 32'(e.nb));
        end
      end
      if (last_accept) begin
        w0[nbits] = b;
        w1[W-1-nbits] = b;
        nbits++;
      end
      if (nbits == W || (FLUSH_EN && f && nbits > 0)) begin
        e.d0 = w0; e.d1 = w1; e.nb = BW'(nbits);
        exp_q.push_back(e);
        nbits = 0; w0 = '0; w1 = '0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a bit until accepted, bounded
  task automatic send_bit(input logic b, input logic r);
    int tries;
    tries = 0;
    last_accept = 1'b0;
    while (!last_accept && tries < 16) begin
      step(1'b1, b, r, 1'b0, 1'b1);
      tries++;
    end
    if (!last_accept) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_byte_lsb(input logic [W-1:0] val, input logic r);
    for (int i = 0; i < W; i++) send_bit(val[i], r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int pc [3];
    int ready_low;
    logic [23:0] stream;

    // Reset values
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(smp_valid), 32'd0);
    check("rst_data", 32'(smp_data0), 32'd0);
    check("rst_bits", 32'(smp_bits0), 32'd0);
    check("rst_ready", 32'(smp_ready), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ready_after_rst", 32'(smp_ready), 32'd1);

    // Basic word 1,0,1,1,0,0,1,0 -> 4D / B2, single-cycle valid
    valid_cycles = 0;
    send_byte_lsb(8'h4D, 1'b1);
    idle(3, 1'b1);
    check("pulse_width", 32'(valid_cycles), 32'd1);

    // Backpressure: FF then 00 with consumer stalled
    for (int k = 0; k < 16; k++) send_bit((k < 8) ? 1'b1 : 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("bp_ready_low", 32'(smp_ready), 32'd0);
      check("bp_ready_low_msb", 32'(smp_ready1), 32'd0);
      check("bp_held_data", 32'(smp_data0), 32'hFF);
      check("bp_held_valid", 32'(smp_valid), 32'd1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_ready_back", 32'(smp_ready), 32'd1);
    check("bp_second_valid", 32'(smp_valid), 32'd1);
    check("bp_second_data", 32'(smp_data0), 32'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_byte_lsb(8'hA5, 1'b1);
    idle(2, 1'b1);

    // Continuous 24 bits: pulses 8 cycles apart, o_ready never low
    stream = 24'hE7813C;
    pulses = 0; ready_low = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, stream[i], 1'b1, 1'b0, 1'b1);
      if (!smp_ready) ready_low++;
      if (smp_valid) begin
        if (pulses < 3) pc[pulses] = cyc;
        pulses++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      if (smp_valid) begin
        if (pulses < 3) pc[pulses] = cyc;
        pulses++;
      end
    end
    check("stream_pulses", 32'(pulses), 32'd3);
    check("stream_ready_low", 32'(ready_low), 32'd0);
    if (pulses == 3) begin
      check("stream_gap1", 32'(pc[1] - pc[0]), 32'd8);
      check("stream_gap2", 32'(pc[2] - pc[1]), 32'd8);
    end

`ifdef BIT_TO_ARRAY_PACKER_FLUSH_EN
    // Partial word flush: 1,1,1 -> 07 / E0 with 3 valid bits
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flush_valid", 32'(smp_valid), 32'd1);
    // Flush with an empty accumulator produces nothing
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flush_empty_valid", 32'(smp_valid), 32'd0);
`endif

    // Reset mid-word discards the partial word
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_valid", 32'(smp_valid), 32'd0);
    check("rst_mid_data", 32'(smp_data0), 32'd0);

    // Reset with a word held at the output
    send_byte_lsb(8'h3C, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("held_before_rst", 32'(smp_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_held_valid", 32'(smp_valid), 32'd0);
    check("rst_held_data", 32'(smp_data0), 32'd0);
    check("rst_held_data_msb", 32'(smp_data1), 32'd0);

    // Next 8 bits form a clean word
    send_byte_lsb(8'h96, 1'b1);
    idle(3, 1'b1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_to_array_packer.md
# bit_to_array_packer

Serial-to-parallel packer that gathers scalar input bits, one per accepted beat, into a `WIDTH`-bit packed word and presents complete words on a valid/ready output.
- The accumulating word is held in the packed-array member of an internal interface instance.
- The block is double-buffered: accumulation continues while the previous word waits at the output.
- It sits between single-bit producers (strap sampling, serial status links) and word-wide consumers.

## Interface
Parameters:
- `WIDTH`, 8, word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 0, bit ordering:
  - 0: first accepted bit lands in bit 0.
  - 1: first accepted bit lands in bit `WIDTH-1`.

Ports:
- `i_clk` input 1 — clock. Every register updates on the rising edge.
- `i_rst_n` input 1 — synchronous, active-low reset.
- `i_valid` input 1 — input bit valid.
- `i_bit` input 1 — scalar data bit.
- `o_ready` output 1 — packer can accept a bit this cycle.
- `i_flush` input 1 — close a partial word (see Configuration).
- `o_valid` output 1 — `o_data` holds a word.
- `i_ready` input 1 — consumer accepts the word.
- `o_data` output `WIDTH` — packed word.
- `o_bits` output `$clog2(WIDTH+1)` — number of valid bits in `o_data`.

## Operation
State and derived signals:
- Internal state: accumulator `acc[WIDTH-1:0]`, count `cnt` (range 0..`WIDTH`), output register (`o_data`, `o_bits`, `o_valid`).
- `accept = i_valid && o_ready`.
- `o_ready = i_rst_n && (cnt != WIDTH)`.
- `out_free = !o_valid || i_ready`.

Bit placement on accept:
- `MSB_FIRST=0`: the bit is written to `acc[cnt]`.
- `MSB_FIRST=1`: the bit is written to `acc[WIDTH-1-cnt]`.
- In both cases `cnt` increments.

Word completion:
- `done = accept && cnt==WIDTH-1`.
- `pending = (cnt==WIDTH)`.

Each cycle:
- `(done || pending) && out_free`:
  - Load `o_data` with the complete word, including the bit accepted this cycle.
  - Set `o_bits = WIDTH` and `o_valid = 1`.
  - Set `cnt = 0` and clear `acc`.
- `done && !out_free`: set `cnt = WIDTH` (pending). `o_ready` drops until the word transfers.
- Otherwise, if `o_valid && i_ready`: clear `o_valid`.
- Output handshake: a word is consumed on any cycle with `o_valid && i_ready`. `o_data` and `o_bits` are stable while `o_valid && !i_ready`.
- Unused `acc` bits are always zero.

Reset (`i_rst_n=0` at an edge):
- `cnt=0`, `acc=0`, `o_valid=0`, `o_data=0`, `o_bits=0`.
- `o_ready` is 0 while reset is asserted and 1 in the first cycle after release.
- Reset mid-word, or with a word pending or held at the output, discards all data silently.

## Timing
- Latency: the last bit accepted at edge N gives `o_valid=1` from edge N onward (visible in cycle N+1).
- Throughput: sustained one bit per cycle with no bubble at word boundaries, provided `i_ready` is high at each word boundary.
- Backpressure:
  - When the output is held and the accumulator completes, the next bit is refused (`o_ready=0`) starting the cycle after `done`.
  - On the edge where the output drains, the pending word loads. `o_ready` returns high the following cycle.
- Simultaneous `done` and output consume in the same cycle: the new word replaces the old one with no gap in `o_valid`.

## Configuration
Macro: `BIT_TO_ARRAY_PACKER_FLUSH_EN`

Defined:
- `i_flush` is sampled when `!pending`.
- Let `n = cnt + accept`. If `n > 0` and `out_free`:
  - The partial word (with this cycle's bit, if any) loads into `o_data`.
  - Missing bit positions are zero: the high end for `MSB_FIRST=0`, the low end for `MSB_FIRST=1`.
  - `o_bits = n`, `o_valid = 1`, `cnt = 0`.
- If `n > 0` and `!out_free`: the flush is ignored and must be held asserted by the source until taken.
- If `n == 0`: the flush is ignored.
- If `n == WIDTH`: behaves as a normal completion.

Undefined:
- `i_flush` is ignored.
- `o_bits` is constant `WIDTH` whenever `o_valid=1`, and 0 after reset.

## Test plan
- Reset, then stream 1,0,1,1,0,0,1,0 with `i_ready=1` and `MSB_FIRST=0` → `o_data=8'h4D`, `o_bits=8`, `o_valid` high for exactly 1 cycle after the 8th accept.
- Same stream with `MSB_FIRST=1` → `o_data=8'hB2`.
- Hold `i_ready=0`; stream 16 bits of 8'hFF then 8'h00 continuously:
  - First word held at `8'hFF`.
  - `o_ready` goes low after bit 16.
  - Raise `i_ready` for 1 cycle → `o_data=8'h00`.
  - `o_ready` high the next cycle.
  - No bit lost.
- Continuous 24-bit stream with `i_ready=1` → three words with `o_valid` pulses exactly 8 cycles apart and `o_ready` never low.
- With FLUSH_EN: accept 1,1,1, then `i_flush=1` → `o_data=8'h07`, `o_bits=3`. Flush with `cnt=0` → no `o_valid`.
- Assert `i_rst_n=0` after 5 bits, and again while a word is held → `o_valid=0`, `o_data=0`. The next 8 bits form a clean word.
